uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller behind uart_rx. It captures each byte reported by the receiver into an internal FIFO and discards errored frames. It tracks error, overrun and idle-timeout conditions and raises one level interrupt. Software or the APB register block drains the FIFO through a pop handshake with a one-cycle read latency.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.
ERR_CNT_W, 8, width of the saturating frame-error counter.
TIMEOUT_W, 16, width of the idle-timeout counter and threshold.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  accept bytes from the receiver when 1.
flush  in  1  empty the FIFO; one-cycle pulse.
rx_data  in  DATA_WIDTH  byte from uart_rx.
rx_done  in  1  one-cycle strobe from uart_rx.
rx_error  in  1  qualifies rx_done; frame errored.
rd_en  in  1  pop request.
rd_data  out  DATA_WIDTH  popped byte, registered.
rd_valid  out  1  rd_data valid; one-cycle pulse.
level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
empty  out  1  level==0.
full  out  1  level==FIFO_DEPTH.
irq_thresh  in  $clog2(FIFO_DEPTH)+1  level interrupt threshold; 0 disables the level source.
timeout_cyc  in  TIMEOUT_W  idle cycles before timeout; 0 disables timeout.
clr_flags  in  1  clears sticky flags and err_cnt.
overrun  out  1  sticky: byte dropped because the FIFO was full.
err_flag  out  1  sticky: at least one errored frame.
timeout  out  1  sticky: idle-timeout fired.
err_cnt  out  ERR_CNT_W  saturating count of errored frames.
irq  out  1  level interrupt.

Behaviour:
- Reset: FIFO empty, level=0, empty=1, full=0, rd_data=0, rd_valid=0, all flags=0, err_cnt=0, irq=0, timeout counter=0.
- Push: the FIFO writes rx_data on rx_done & !rx_error & enable & (!full | pop_this_cycle).
- Push while full with no pop: the byte is dropped and overrun is set. Stored data is unchanged.
- Errored frame: on rx_done & rx_error & enable, the byte is discarded, err_flag is set, and err_cnt increments, saturating at all-ones.
- enable=0: rx_done is ignored completely, with no flags and no count. Pops and flush still operate.
- Pop: rd_en & !empty. Next cycle rd_data holds the oldest byte and rd_valid=1.
- rd_en while empty is ignored, with rd_valid=0. rd_data holds its last value.
- Simultaneous push and pop:
  - When not empty, both occur and level is unchanged.
  - When full, both occur and no overrun is raised.
  - When empty, only the push occurs; there is no bypass path.
- flush: pointers and level go to 0 next cycle. A push or pop in the same cycle is discarded. rd_valid is not asserted. Sticky flags are unchanged.
- Timeout counter:
  - Clears on push, pop, flush, or level==0.
  - Otherwise increments each cycle while level>0 and timeout_cyc!=0.
  - When the count equals timeout_cyc-1, timeout sets on the next edge and the counter clears.
- clr_flags clears overrun, err_flag, timeout and err_cnt. A new event in the same cycle wins: the flag stays set and err_cnt becomes 1.
- irq is registered and equals ((irq_thresh!=0) & (level>=irq_thresh)) | overrun | err_flag | timeout, evaluated on the next-state values. irq therefore asserts in the same cycle as the condition becomes visible on the outputs.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. level is tracked separately.
- Reset asserted mid-operation returns everything to reset values asynchronously. FIFO contents are lost.

Decomposition:
- shared_pkg holds DATA_WIDTH (existing), UART_RX_FIFO_DEPTH as the default for FIFO_DEPTH, and typedef struct uart_rx_status_t {overrun, err_flag, timeout, err_cnt} for the register block.
- Sub-module uart_rx_fifo: synchronous FIFO with push, pop, flush, rd_data/rd_valid, level, full and empty. Flag, counter and irq logic stays in uart_rx_ctrl.

Test Plan:
- Fill and drain: 3 good frames 0xA5, 0x3C, 0xFF, then rd_en x3 → rd_data A5, 3C, FF with rd_valid one cycle after each rd_en; level 3→0; irq stays 0 with irq_thresh=0 and timeout_cyc=0.
- Overrun: FIFO_DEPTH=16, push 17 good frames with no pops → full=1, overrun=1, irq=1; draining returns the first 16 bytes in order and the 17th is absent.
- Errors: 300 frames with rx_error=1 → err_cnt=255 (saturated), err_flag=1, level=0; clr_flags → err_cnt=0, err_flag=0, irq=0.
- Timeout: timeout_cyc=100, one good byte, no pops → timeout=1 exactly 100 cycles after the push edge; a pop at cycle 50 prevents the timeout.
- Simultaneous events:
  - Push and pop on a full FIFO → level stays 16, overrun=0.
  - Push and pop on an empty FIFO → level=1, rd_valid=0.
  - clr_flags together with an errored frame → err_flag=1, err_cnt=1.
- Reset and flush: flush with level=5 → level=0, empty=1, flags unchanged; rst_n low mid-frame → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared UART receive-path constants and the status record handed to the register block.
package shared_pkg;

  localparam int unsigned DATA_WIDTH         = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;
  localparam int unsigned UART_RX_ERR_CNT_W  = 8;

  typedef struct packed {
    logic                         overrun;
    logic                         err_flag;
    logic                         timeout;
    logic [UART_RX_ERR_CNT_W-1:0] err_cnt;
  } uart_rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO: registered pop data, separate level tracking, flush wins over push/pop.
module uart_rx_fifo
  import shared_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned DW    = DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       push_ok_c,
  output logic                       pop_ok_c,
  output logic [$clog2(DEPTH):0]     level_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // A pop needs data; a push into a full FIFO is legal only when a pop frees the slot.
  assign pop_ok_c  = pop & ~empty & ~flush;
  assign push_ok_c = push & (~full | pop_ok_c) & ~flush;

  always_comb begin
    level_nxt_c = level;
    if (flush) begin
      level_nxt_c = '0;
    end else begin
      case ({push_ok_c, pop_ok_c})
        2'b10:   level_nxt_c = level + LW'(1);
        2'b01:   level_nxt_c = level - LW'(1);
        default: level_nxt_c = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      level    <= level_nxt_c;
      empty    <= (level_nxt_c == '0);
      full     <= (level_nxt_c == LW'(DEPTH));
      rd_valid <= pop_ok_c;
      if (pop_ok_c) begin
        rd_data <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers good frames, tracks error/overrun/timeout and drives one level irq.
module uart_rx_ctrl
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned ERR_CNT_W  = UART_RX_ERR_CNT_W,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_done,
  input  logic                          rx_error,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          empty,
  output logic                          full,
  input  logic [$clog2(FIFO_DEPTH):0]   irq_thresh,
  input  logic [TIMEOUT_W-1:0]          timeout_cyc,
  input  logic                          clr_flags,
  output logic                          overrun,
  output logic                          err_flag,
  output logic                          timeout,
  output logic [ERR_CNT_W-1:0]          err_cnt,
  output logic                          irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 frame_ok_c;
  logic                 frame_bad_c;
  logic                 push_ok_c;
  logic                 pop_ok_c;
  logic                 ovr_ev_c;
  logic                 to_ev_c;
  logic [LW-1:0]        level_nxt_c;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] tcnt_nxt_c;
  logic                 overrun_nxt_c;
  logic                 err_flag_nxt_c;
  logic                 timeout_nxt_c;
  logic [ERR_CNT_W-1:0] err_cnt_nxt_c;
  logic                 irq_nxt_c;

  assign frame_ok_c  = rx_done & enable & ~rx_error;
  assign frame_bad_c = rx_done & enable &  rx_error;
  // A good byte the FIFO refused for lack of room; flush-discarded bytes are not overruns.
  assign ovr_ev_c    = frame_ok_c & ~push_ok_c & ~flush;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (frame_ok_c),
    .push_data   (rx_data),
    .pop         (rd_en),
    .flush       (flush),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .push_ok_c   (push_ok_c),
    .pop_ok_c    (pop_ok_c),
    .level_nxt_c (level_nxt_c)
  );

  // Idle timer: any FIFO activity or an empty FIFO restarts it.
  always_comb begin
    tcnt_nxt_c = tcnt;
    to_ev_c    = 1'b0;
    if (push_ok_c || pop_ok_c || flush || empty) begin
      tcnt_nxt_c = '0;
    end else if (timeout_cyc != '0) begin
      if (tcnt == timeout_cyc - TIMEOUT_W'(1)) begin
        to_ev_c    = 1'b1;
        tcnt_nxt_c = '0;
      end else begin
        tcnt_nxt_c = tcnt + TIMEOUT_W'(1);
      end
    end
  end

  // Sticky flags: a same-cycle event beats clr_flags.
  always_comb begin
    overrun_nxt_c  = (overrun  & ~clr_flags) | ovr_ev_c;
    err_flag_nxt_c = (err_flag & ~clr_flags) | frame_bad_c;
    timeout_nxt_c  = (timeout  & ~clr_flags) | to_ev_c;
    err_cnt_nxt_c  = clr_flags ? '0 : err_cnt;
    if (frame_bad_c && (clr_flags || (err_cnt != '1))) begin
      err_cnt_nxt_c = err_cnt_nxt_c + ERR_CNT_W'(1);
    end
    irq_nxt_c = ((irq_thresh != '0) && (level_nxt_c >= irq_thresh))
              | overrun_nxt_c | err_flag_nxt_c | timeout_nxt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= '0;
      overrun  <= 1'b0;
      err_flag <= 1'b0;
      timeout  <= 1'b0;
      err_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      tcnt     <= tcnt_nxt_c;
      overrun  <= overrun_nxt_c;
      err_flag <= err_flag_nxt_c;
      timeout  <= timeout_nxt_c;
      err_cnt  <= err_cnt_nxt_c;
      irq      <= irq_nxt_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        rx_error = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic [4:0]  irq_thresh = '0;
  logic [15:0] timeout_cyc = '0;
  logic        clr_flags = 1'b0;
  logic        overrun;
  logic        err_flag;
  logic        timeout;
  logic [7:0]  err_cnt;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  uart_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .empty(empty), .full(full),
    .irq_thresh(irq_thresh), .timeout_cyc(timeout_cyc), .clr_flags(clr_flags),
    .overrun(overrun), .err_flag(err_flag), .timeout(timeout), .err_cnt(err_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue, flags follow the event rules directly.
  logic [7:0] q[$];
  logic [7:0] m_rd_data = '0;
  bit         m_rd_valid = 0, m_ovr = 0, m_err = 0, m_to = 0, m_irq = 0;
  int         m_err_cnt = 0;
  int         m_idle = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 0; m_ovr = 0; m_err = 0; m_to = 0;
      m_irq = 0; m_err_cnt = 0; m_idle = 0;
    end else begin
      bit good, bad, do_pop, do_push, ovr_ev, to_ev;
      int old_n;
      old_n   = q.size();
      good    = rx_done && enable && !rx_error;
      bad     = rx_done && enable && rx_error;
      do_pop  = rd_en && old_n > 0 && !flush;
      do_push = good && (old_n < DEPTH || do_pop) && !flush;
      ovr_ev  = good && !do_push && !flush;
      to_ev   = 0;
      m_rd_valid = do_pop;
      if (do_pop)  m_rd_data = q.pop_front();
      if (do_push) q.push_back(rx_data);
      if (flush)   q.delete();
      if (do_push || do_pop || flush || old_n == 0) m_idle = 0;
      else if (timeout_cyc != 0) begin
        if (m_idle == int'(timeout_cyc) - 1) begin to_ev = 1; m_idle = 0; end
        else m_idle++;
      end
      if (clr_flags) begin m_ovr = 0; m_err = 0; m_to = 0; m_err_cnt = 0; end
      m_ovr = m_ovr | ovr_ev;
      m_err = m_err | bad;
      m_to  = m_to | to_ev;
      if (bad && m_err_cnt < 255) m_err_cnt++;
      m_irq = (irq_thresh != 0 && q.size() >= int'(irq_thresh)) || m_ovr || m_err || m_to;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("level",    int'(level),    q.size());
      chk("empty",    int'(empty),    int'(q.size() == 0));
      chk("full",     int'(full),     int'(q.size() == DEPTH));
      chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
      chk("rd_data",  int'(rd_data),  int'(m_rd_data));
      chk("overrun",  int'(overrun),  int'(m_ovr));
      chk("err_flag", int'(err_flag), int'(m_err));
      chk("timeout",  int'(timeout),  int'(m_to));
      chk("err_cnt",  int'(err_cnt),  m_err_cnt);
      chk("irq",      int'(irq),      int'(m_irq));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input bit err);
    rx_data = d; rx_done = 1'b1; rx_error = err;
    tick();
    rx_done = 1'b0; rx_error = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    logic [7:0] fd [3];
    int n;
    fd[0] = 8'hA5; fd[1] = 8'h3C; fd[2] = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1;
    cmp_en = 1'b1;
    chk("reset_empty", int'(empty), 1);
    chk("reset_level", int'(level), 0);

    // Fill and drain
    for (int i = 0; i < 3; i++) send(fd[i], 0);
    chk("fd_level3", int'(level), 3);
    for (int i = 0; i < 3; i++) begin
      pop1();
      chk("fd_valid", int'(rd_valid), 1);
      chk("fd_data", int'(rd_data), int'(fd[i]));
    end
    chk("fd_level0", int'(level), 0);
    chk("fd_irq", int'(irq), 0);

    // Overrun
    for (int i = 0; i < 17; i++) send(8'(8'h10 + i), 0);
    chk("ovr_full", int'(full), 1);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_irq", int'(irq), 1);
    for (int i = 0; i < 16; i++) begin
      pop1();
      chk("ovr_data", int'(rd_data), 16 + i);
    end
    pop1();
    chk("ovr_17th_absent", int'(rd_valid), 0);
    pulse_clr();

    // Errored frames saturate the counter
    for (int i = 0; i < 300; i++) send(8'(i), 1);
    chk("err_sat", int'(err_cnt), 255);
    chk("err_flag", int'(err_flag), 1);
    chk("err_level", int'(level), 0);
    pulse_clr();
    chk("clr_cnt", int'(err_cnt), 0);
    chk("clr_flag", int'(err_flag), 0);
    chk("clr_irq", int'(irq), 0);

    // Idle timeout fires 100 edges after the push edge
    timeout_cyc = 16'd100;
    send(8'h55, 0);
    n = 0;
    while (!timeout && n < 200) begin tick(); n++; end
    chk("to_cycles", n, 100);
    pop1();
    pulse_clr();
    send(8'h01, 0);
    send(8'h02, 0);
    repeat (49) tick();
    pop1();
    repeat (69) tick();
    chk("to_prevented", int'(timeout), 0);
    pop1();
    timeout_cyc = '0;

    // Push and pop on a full FIFO
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    rd_en = 1'b1;
    send(8'hEE, 0);
    rd_en = 1'b0;
    chk("fullpp_level", int'(level), 16);
    chk("fullpp_ovr", int'(overrun), 0);
    chk("fullpp_valid", int'(rd_valid), 1);
    for (int i = 0; i < 16; i++) pop1();

    // Push and pop on an empty FIFO: no bypass
    rd_en = 1'b1;
    send(8'h77, 0);
    rd_en = 1'b0;
    chk("emptypp_level", int'(level), 1);
    chk("emptypp_valid", int'(rd_valid), 0);

    // clr_flags loses to a same-cycle errored frame
    clr_flags = 1'b1;
    send(8'h00, 1);
    clr_flags = 1'b0;
    chk("clr_err_flag", int'(err_flag), 1);
    chk("clr_err_cnt", int'(err_cnt), 1);

    // Flush at level 5 keeps flags
    for (int i = 0; i < 4; i++) send(8'(i), 0);
    chk("fl_level5", int'(level), 5);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_level", int'(level), 0);
    chk("fl_empty", int'(empty), 1);
    chk("fl_flag", int'(err_flag), 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        irq_thresh  = 5'($urandom_range(0, 16));
        timeout_cyc = 16'($urandom_range(0, 12));
      end
      enable    = ($urandom_range(0, 9) != 0);
      rx_done   = ($urandom_range(0, 1) == 1);
      rx_error  = ($urandom_range(0, 9) == 0);
      rx_data   = 8'($urandom);
      rd_en     = ($urandom_range(0, 9) < 4);
      flush     = ($urandom_range(0, 49) == 0);
      clr_flags = ($urandom_range(0, 29) == 0);
      tick();
    end
    rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_flags = 1'b0; enable = 1'b1;

    // Asynchronous reset in the middle of a frame
    send(8'h9A, 0);
    rx_data = 8'h42; rx_done = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_irq", int'(irq), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rx_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
